// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store memory master.
// Holds the FSM state encoding, funct3 codes and the request legality checks.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LD,
    ST,
    RMW_RD,
    RMW_WR,
    RESP,
    ERR
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_H, F3_HU: return addr_lo[0];
      F3_W:        return (addr_lo != 2'b00);
      default:     return 1'b0;
    endcase
  endfunction

  // Stores only have signed-size encodings; unsigned variants are load-only.
  function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
    if (we) return !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
    return !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W ||
             funct3 == F3_BU || funct3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Byte/half lane steering: load extraction with sign/zero extension and
// the read-modify-write merge used for SB/SH on a memory without byte enables.
module lsu_data_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] old,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        addr_lo,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] ext,
  output logic [DATA_W-1:0] merged
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[{addr_lo, 3'b000} +: 8];
    half_v = rdata[{addr_lo[1], 4'b0000} +: 16];
    ext    = rdata;
    case (funct3)
      F3_B:    ext = {{24{byte_v[7]}}, byte_v};
      F3_BU:   ext = {24'h000000, byte_v};
      F3_H:    ext = {{16{half_v[15]}}, half_v};
      F3_HU:   ext = {16'h0000, half_v};
      default: ext = rdata;
    endcase
  end

  always_comb begin
    merged = old;
    case (funct3)
      F3_B:    merged[{addr_lo, 3'b000} +: 8]     = wdata[7:0];
      F3_H:    merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      F3_W:    merged = wdata;
      default: merged = old;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator between the MEM stage and a word-addressed data memory.
// One request per handshake; SB/SH go through a read-modify-write sequence.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_e        state, next_state;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, old_q, rdata_q;
  logic [DATA_W-1:0] ext, merged;

  lsu_data_align #(.DATA_W(DATA_W)) u_align (
    .rdata   (mem_rdata),
    .old     (old_q),
    .wdata   (wdata_q),
    .addr_lo (addr_q[1:0]),
    .funct3  (f3_q),
    .ext     (ext),
    .merged  (merged)
  );

  // addr_q is reset so mem_addr reads zero straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      we_q   <= 1'b0;
      f3_q   <= 3'b000;
      addr_q <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && req_valid) begin
        we_q   <= req_we;
        f3_q   <= req_funct3;
        addr_q <= req_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) wdata_q <= req_wdata;
    if (state == LD)                rdata_q <= ext;
    if (state == RMW_RD)            old_q   <= mem_rdata;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (is_illegal(req_we, req_funct3) || is_misaligned(req_funct3, req_addr[1:0]))
            next_state = ERR;
          else if (!req_we)
            next_state = LD;
          else if (req_funct3 == F3_W)
            next_state = ST;
          else
            next_state = RMW_RD;
        end
      end
      LD:      next_state = RESP;
      ST:      next_state = RESP;
      RMW_RD:  next_state = RMW_WR;
      RMW_WR:  next_state = RESP;
      RESP:    next_state = IDLE;
      ERR:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP) || (state == ERR);
    rsp_err   = (state == ERR);
    rsp_rdata = (state == RESP && !we_q) ? rdata_q : '0;
    mem_re    = (state == LD) || (state == RMW_RD);
    mem_we    = (state == ST) || (state == RMW_WR);
    mem_addr  = {2'b00, addr_q[ADDR_W-1:2]};
    mem_wdata = '0;
    if (state == ST)     mem_wdata = wdata_q;
    if (state == RMW_WR) mem_wdata = merged;
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master against a small combinational-read data memory,
// with a response scoreboard, per-op timing checks and reset/back-to-back sequences.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err, mem_we, mem_re;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        preload;

  always #5 clk = ~clk;

  lsu_mem_master #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  logic [31:0] dmem [16];
  assign mem_rdata = dmem[mem_addr[3:0]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) dmem[i] <= 32'h0;
      dmem[0] <= 32'h8000_00FF;
      dmem[3] <= 32'h1234_5678;
    end else if (mem_we) begin
      dmem[mem_addr[3:0]] <= mem_wdata;
    end
  end

  int tests = 0;
  int fails = 0;

  typedef struct { logic [31:0] rdata; logic err; } resp_t;
  resp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mem_we && mem_re) begin
      fails++;
      $display("FAIL we_re_overlap: got we=1 re=1 expected at most one");
    end
    if (rsp_valid) begin
      if (sbq.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_rsp: got rdata=0x%08h err=%0b expected no response", rsp_rdata, rsp_err);
      end else begin
        resp_t e;
        e = sbq.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
      end
    end
  end

  typedef struct {
    logic we; logic [2:0] f3; logic [31:0] addr; logic [31:0] wdata;
    logic [31:0] exp_rdata; logic exp_err; int lat; int re_cyc; int we_cyc; logic [31:0] exp_mwd;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_rdata,
                              input logic exp_err, input int lat, input int re_cyc,
                              input int we_cyc, input logic [31:0] exp_mwd);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.exp_rdata = exp_rdata;
    v.exp_err = exp_err; v.lat = lat; v.re_cyc = re_cyc; v.we_cyc = we_cyc; v.exp_mwd = exp_mwd;
    return v;
  endfunction

  task automatic run_op(input vec_t v);
    int seen_re, seen_we, lat;
    logic [31:0] wd;
    logic bad_addr, bad_ready;
    resp_t e;
    seen_re = 0; seen_we = 0; lat = 0; wd = 32'h0; bad_addr = 1'b0; bad_ready = 1'b0;
    @(negedge clk);
    chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    e.rdata = v.exp_rdata; e.err = v.exp_err;
    sbq.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (req_ready) bad_ready = 1'b1;
      if (mem_re && seen_re == 0) seen_re = c;
      if (mem_we && seen_we == 0) begin seen_we = c; wd = mem_wdata; end
      if ((mem_re || mem_we) && mem_addr !== {2'b00, v.addr[31:2]}) bad_addr = 1'b1;
      if (rsp_valid) begin lat = c; break; end
    end
    if (lat == 0) begin
      tests++; fails++;
      $display("FAIL rsp_timeout: got no rsp_valid in 8 cycles expected latency %0d", v.lat);
    end else begin
      chk("latency", lat, v.lat);
    end
    chk("mem_re_cycle", seen_re, v.re_cyc);
    chk("mem_we_cycle", seen_we, v.we_cyc);
    if (v.we_cyc != 0) chk("mem_wdata", wd, v.exp_mwd);
    chk("mem_addr_stable", {31'h0, bad_addr}, 32'h0);
    chk("req_ready_busy", {31'h0, bad_ready}, 32'h0);
  endtask

  vec_t vecs [20];

  initial begin
    rst = 1'b1; preload = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;

    //        we    f3      addr   wdata        exp_rdata     err lat re we exp_mwd
    vecs[0]  = mk(1'b0, 3'b010, 32'h0C, 32'h0,       32'h1234_5678, 0, 2, 1, 0, 32'h0);
    vecs[1]  = mk(1'b0, 3'b000, 32'h00, 32'h0,       32'hFFFF_FFFF, 0, 2, 1, 0, 32'h0);
    vecs[2]  = mk(1'b0, 3'b100, 32'h03, 32'h0,       32'h0000_0080, 0, 2, 1, 0, 32'h0);
    vecs[3]  = mk(1'b0, 3'b001, 32'h02, 32'h0,       32'hFFFF_8000, 0, 2, 1, 0, 32'h0);
    vecs[4]  = mk(1'b0, 3'b001, 32'h00, 32'h0,       32'h0000_00FF, 0, 2, 1, 0, 32'h0);
    vecs[5]  = mk(1'b1, 3'b000, 32'h0D, 32'h0000_00AB, 32'h0,       0, 3, 1, 2, 32'h1234_AB78);
    vecs[6]  = mk(1'b0, 3'b010, 32'h0C, 32'h0,       32'h1234_AB78, 0, 2, 1, 0, 32'h0);
    vecs[7]  = mk(1'b0, 3'b010, 32'h06, 32'h0,       32'h0,         1, 1, 0, 0, 32'h0);
    vecs[8]  = mk(1'b1, 3'b001, 32'h03, 32'hFFFF_FFFF, 32'h0,       1, 1, 0, 0, 32'h0);
    vecs[9]  = mk(1'b0, 3'b010, 32'h0C, 32'h0,       32'h1234_AB78, 0, 2, 1, 0, 32'h0);
    vecs[10] = mk(1'b1, 3'b010, 32'h08, 32'hDEAD_BEEF, 32'h0,       0, 2, 0, 1, 32'hDEAD_BEEF);
    vecs[11] = mk(1'b0, 3'b010, 32'h08, 32'h0,       32'hDEAD_BEEF, 0, 2, 1, 0, 32'h0);
    vecs[12] = mk(1'b1, 3'b001, 32'h0A, 32'h5555_CAFE, 32'h0,       0, 3, 1, 2, 32'hCAFE_BEEF);
    vecs[13] = mk(1'b0, 3'b000, 32'h0B, 32'h0,       32'hFFFF_FFCA, 0, 2, 1, 0, 32'h0);
    vecs[14] = mk(1'b0, 3'b101, 32'h0A, 32'h0,       32'h0000_CAFE, 0, 2, 1, 0, 32'h0);
    vecs[15] = mk(1'b0, 3'b011, 32'h00, 32'h0,       32'h0,         1, 1, 0, 0, 32'h0);
    vecs[16] = mk(1'b1, 3'b100, 32'h04, 32'h0000_0077, 32'h0,       1, 1, 0, 0, 32'h0);
    vecs[17] = mk(1'b0, 3'b010, 32'h04, 32'h0,       32'h0,         0, 2, 1, 0, 32'h0);
    vecs[18] = mk(1'b0, 3'b100, 32'h01, 32'h0,       32'h0,         0, 2, 1, 0, 32'h0);
    vecs[19] = mk(1'b0, 3'b010, 32'h00, 32'h0,       32'h8000_00FF, 0, 2, 1, 0, 32'h0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_mem_we_re", {30'h0, mem_we, mem_re}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    rst = 1'b0; preload = 1'b0;

    for (int i = 0; i < 20; i++) run_op(vecs[i]);

    // Back-to-back: request held valid; ready only in IDLE, one op every 3 cycles.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0C; req_wdata = 32'h0;
    for (int i = 0; i < 6; i++) begin
      if (i != 0) @(negedge clk);
      chk("b2b_req_ready", {31'h0, req_ready}, {31'h0, (i % 3 == 0)});
      if (req_ready) begin
        resp_t e;
        e.rdata = 32'h1234_AB78; e.err = 1'b0;
        sbq.push_back(e);
      end
    end
    @(negedge clk);
    req_valid = 1'b0;

    // Reset during the read half of an SH: op abandoned, no write.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h08; req_wdata = 32'h0000_1111;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_rd_mem_re", {31'h0, mem_re}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("midrst_outputs", {29'h0, rsp_valid, mem_we, mem_re}, 32'h0);
    chk("midrst_mem_addr", mem_addr, 32'h0);
    run_op(mk(1'b0, 3'b010, 32'h08, 32'h0, 32'hCAFE_BEEF, 0, 2, 1, 0, 32'h0));

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
